// File: rtl/ir_key_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ir_key_event_decoder                                         |
// | Description : Turns 12-bit IR frames into press/release key events.       |
// |               Filters on address, tracks key-hold over repeat frames and   |
// |               queues events in a first-word-fall-through FIFO.             |
// |               Optional macro IR_KEY_REPEAT_EN adds repeat events and the   |
// |               evt_repeat head field.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ir_key_event_decoder #(
  parameter int         RELEASE_TIMEOUT = 3000000,
  parameter logic [4:0] ADDR_MASK       = 5'h00,
  parameter logic [4:0] ADDR_MATCH      = 5'h01,
  parameter int         FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] ir_data,
  input  logic        ir_data_rdy,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_release,
  output logic [6:0]  evt_cmd,
  output logic [4:0]  evt_addr,
  output logic        key_held,
  output logic [6:0]  held_cmd,
  output logic        overflow
`ifdef IR_KEY_REPEAT_EN
  ,
  output logic        evt_repeat
`endif
);

  localparam int TW = $clog2(RELEASE_TIMEOUT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef IR_KEY_REPEAT_EN
  localparam int EW = 14;
`else
  localparam int EW = 13;
`endif

  localparam logic [TW-1:0] C_TMO_LAST = TW'(RELEASE_TIMEOUT - 1);
  localparam logic [TW-1:0] C_TMO_SAT  = TW'(RELEASE_TIMEOUT);
  localparam logic [CW-1:0] C_FULL     = CW'(FIFO_DEPTH);
  localparam logic [0:0]    C_IDLE     = 1'b0;
  localparam logic [0:0]    C_HELD     = 1'b1;

  logic          rdy_q,       rdy_d;
  logic [0:0]    state_q,     state_d;
  logic [TW-1:0] timer_q,     timer_d;
  logic [6:0]    held_cmd_q,  held_cmd_d;
  logic [4:0]    held_addr_q, held_addr_d;
  logic          ovf_q,       ovf_d;
  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];

  logic          det;
  logic          accept;
  logic          same_code;
  logic [6:0]    frame_cmd;
  logic [4:0]    frame_addr;
  logic          push_req;
  logic          push_rel;
  logic [6:0]    push_cmd;
  logic [4:0]    push_addr;
  logic [EW-1:0] push_entry;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic [EW-1:0] head;
`ifdef IR_KEY_REPEAT_EN
  logic          push_rep;
`endif

  // Frame field split, rising-edge detection of data_rdy and address filter
  assign frame_cmd  = ir_data[6:0];
  assign frame_addr = ir_data[11:7];
  assign det        = ir_data_rdy & ~rdy_q;
  assign accept     = det & ((frame_addr & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK));
  assign same_code  = (frame_cmd == held_cmd_q) && (frame_addr == held_addr_q);
  assign rdy_d      = ir_data_rdy;

`ifdef IR_KEY_REPEAT_EN
  assign push_entry = {push_rep, push_rel, push_addr, push_cmd};
`else
  assign push_entry = {push_rel, push_addr, push_cmd};
`endif

  // Key-hold state machine: decides which event (if any) to push this cycle
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    held_cmd_d  = held_cmd_q;
    held_addr_d = held_addr_q;
    push_req    = 1'b0;
    push_rel    = 1'b0;
    push_cmd    = 7'h00;
    push_addr   = 5'h00;
`ifdef IR_KEY_REPEAT_EN
    push_rep    = 1'b0;
`endif
    case (state_q)
      C_IDLE: begin
        if (accept) begin
          push_req    = 1'b1;
          push_cmd    = frame_cmd;
          push_addr   = frame_addr;
          held_cmd_d  = frame_cmd;
          held_addr_d = frame_addr;
          timer_d     = '0;
          state_d     = C_HELD;
        end
      end
      C_HELD: begin
        // A frame arriving on the timeout cycle keeps the key held
        if (accept) begin
          timer_d = '0;
          if (!same_code) begin
            push_req    = 1'b1;
            push_cmd    = frame_cmd;
            push_addr   = frame_addr;
            held_cmd_d  = frame_cmd;
            held_addr_d = frame_addr;
          end
`ifdef IR_KEY_REPEAT_EN
          else begin
            push_req  = 1'b1;
            push_rep  = 1'b1;
            push_cmd  = frame_cmd;
            push_addr = frame_addr;
          end
`endif
        end else if (timer_q == C_TMO_LAST) begin
          push_req  = 1'b1;
          push_rel  = 1'b1;
          push_cmd  = held_cmd_q;
          push_addr = held_addr_q;
          timer_d   = '0;
          state_d   = C_IDLE;
        end else if (timer_q != C_TMO_SAT) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Event FIFO bookkeeping: full-with-pop still accepts, full-without-pop drops
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    full     = (cnt_q == C_FULL);
    pop      = evt_valid & evt_ready;
    push_ok  = push_req & (~full | pop);
    ovf_d    = ovf_q | (push_req & full & ~pop);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Head fields read zero whenever the FIFO is empty
  assign head        = mem_q[rd_ptr_q];
  assign evt_valid   = (cnt_q != '0);
  assign evt_release = evt_valid & head[12];
  assign evt_addr    = evt_valid ? head[11:7] : 5'h00;
  assign evt_cmd     = evt_valid ? head[6:0] : 7'h00;
`ifdef IR_KEY_REPEAT_EN
  assign evt_repeat  = evt_valid & head[13];
`endif
  assign key_held    = (state_q == C_HELD);
  assign held_cmd    = held_cmd_q;
  assign overflow    = ovf_q;

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      state_q     <= C_IDLE;
      timer_q     <= '0;
      held_cmd_q  <= 7'h00;
      held_addr_q <= 5'h00;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      mem_q       <= '{default: '0};
    end else begin
      rdy_q       <= rdy_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      held_cmd_q  <= held_cmd_d;
      held_addr_q <= held_addr_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_key_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ir_key_event_decoder                                      |
// | Description : Self-checking bench for ir_key_event_decoder: directed key   |
// |               scenarios plus random frames against a list-based model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ir_key_event_decoder;

  localparam int         RT         = 100;
  localparam int         DEPTH      = 4;
  localparam logic [4:0] MAIN_MASK  = 5'h00;
  localparam logic [4:0] MAIN_MATCH = 5'h01;
`ifdef IR_KEY_REPEAT_EN
  localparam int EXP_REPEATS = 4;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [11:0] ir_data;
  logic        ir_data_rdy;
  logic        evt_ready;
  logic        evt_valid, evt_release, key_held, overflow;
  logic [6:0]  evt_cmd, held_cmd;
  logic [4:0]  evt_addr;
  logic        rep_bit;

  logic [11:0] f_data;
  logic        f_rdy, f_ready;
  logic        f_valid, f_release, f_key_held, f_overflow;
  logic [6:0]  f_cmd, f_held_cmd;
  logic [4:0]  f_addr;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IR_KEY_REPEAT_EN
  logic evt_repeat, f_repeat;
  assign rep_bit = evt_repeat;
`else
  assign rep_bit = 1'b0;
`endif

  ir_key_event_decoder #(
    .RELEASE_TIMEOUT(RT), .ADDR_MASK(MAIN_MASK), .ADDR_MATCH(MAIN_MATCH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ir_data(ir_data), .ir_data_rdy(ir_data_rdy),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_release(evt_release),
    .evt_cmd(evt_cmd), .evt_addr(evt_addr), .key_held(key_held),
    .held_cmd(held_cmd), .overflow(overflow)
`ifdef IR_KEY_REPEAT_EN
    , .evt_repeat(evt_repeat)
`endif
  );

  ir_key_event_decoder #(
    .RELEASE_TIMEOUT(RT), .ADDR_MASK(5'h1F), .ADDR_MATCH(5'h01), .FIFO_DEPTH(DEPTH)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .ir_data(f_data), .ir_data_rdy(f_rdy),
    .evt_valid(f_valid), .evt_ready(f_ready), .evt_release(f_release),
    .evt_cmd(f_cmd), .evt_addr(f_addr), .key_held(f_key_held),
    .held_cmd(f_held_cmd), .overflow(f_overflow)
`ifdef IR_KEY_REPEAT_EN
    , .evt_repeat(f_repeat)
`endif
  );

  // Reference model: ordered event list (index 0 = oldest), key state and
  // the cycle number of the last accepted frame.
  typedef struct packed {
    logic       rel;
    logic       rep;
    logic [4:0] addr;
    logic [6:0] cmd;
  } ev_t;

  ev_t        m_list [DEPTH];
  ev_t        n_list [DEPTH];
  int         m_n, n_n, m_cyc, m_last, n_last;
  logic       m_held, n_held, m_ovf, n_ovf, m_prev;
  logic [6:0] m_hcmd, n_hcmd;
  logic [4:0] m_haddr, n_haddr;
  logic       m_have, m_acc;
  ev_t        m_ev;

  always_comb begin
    n_list  = m_list;
    n_n     = m_n;
    n_held  = m_held;
    n_hcmd  = m_hcmd;
    n_haddr = m_haddr;
    n_last  = m_last;
    n_ovf   = m_ovf;
    m_have  = 1'b0;
    m_ev    = '0;
    m_acc   = ir_data_rdy && !m_prev &&
              ((ir_data[11:7] & MAIN_MASK) == (MAIN_MATCH & MAIN_MASK));
    if (m_acc) begin
      if (m_held && ir_data[6:0] == m_hcmd && ir_data[11:7] == m_haddr) begin
`ifdef IR_KEY_REPEAT_EN
        m_have = 1'b1;
        m_ev   = '{rel: 1'b0, rep: 1'b1, addr: ir_data[11:7], cmd: ir_data[6:0]};
`endif
      end else begin
        m_have  = 1'b1;
        m_ev    = '{rel: 1'b0, rep: 1'b0, addr: ir_data[11:7], cmd: ir_data[6:0]};
        n_hcmd  = ir_data[6:0];
        n_haddr = ir_data[11:7];
      end
      n_held = 1'b1;
      n_last = m_cyc;
    end else if (m_held && (m_cyc - m_last) == RT) begin
      m_have = 1'b1;
      m_ev   = '{rel: 1'b1, rep: 1'b0, addr: m_haddr, cmd: m_hcmd};
      n_held = 1'b0;
    end
    if (m_n != 0 && evt_ready) begin
      for (int i = 0; i < DEPTH - 1; i++) n_list[i] = m_list[i+1];
      n_list[DEPTH-1] = '0;
      n_n = m_n - 1;
    end
    if (m_have) begin
      if (n_n < DEPTH) begin
        n_list[n_n] = m_ev;
        n_n = n_n + 1;
      end else begin
        n_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_list  <= '{default: '0};
      m_n     <= 0;
      m_cyc   <= 0;
      m_last  <= 0;
      m_held  <= 1'b0;
      m_ovf   <= 1'b0;
      m_prev  <= 1'b0;
      m_hcmd  <= 7'h00;
      m_haddr <= 5'h00;
    end else begin
      m_list  <= n_list;
      m_n     <= n_n;
      m_cyc   <= m_cyc + 1;
      m_last  <= n_last;
      m_held  <= n_held;
      m_ovf   <= n_ovf;
      m_prev  <= ir_data_rdy;
      m_hcmd  <= n_hcmd;
      m_haddr <= n_haddr;
    end
  end

  // One-cycle data_rdy pulse on the main DUT; returns at the negedge where a
  // resulting event is first visible.
  task automatic send_frame(input logic [11:0] d);
    ir_data     = d;
    ir_data_rdy = 1'b1;
    @(negedge clk);
    ir_data_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; evt_ready = 1'b0; ir_data = 12'h000; ir_data_rdy = 1'b0;
    f_data = 12'h000; f_rdy = 1'b0; f_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    checks++; if (evt_release !== 1'b0) begin failures++; $display("FAIL reset_release: got %b want 0", evt_release); end
    checks++; if (evt_cmd !== 7'h00) begin failures++; $display("FAIL reset_cmd: got %h want 00", evt_cmd); end
    checks++; if (evt_addr !== 5'h00) begin failures++; $display("FAIL reset_addr: got %h want 00", evt_addr); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_key_held: got %b want 0", key_held); end
    checks++; if (held_cmd !== 7'h00) begin failures++; $display("FAIL reset_held_cmd: got %h want 00", held_cmd); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (rep_bit !== 1'b0) begin failures++; $display("FAIL reset_repeat: got %b want 0", rep_bit); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    evt_ready = 1'b0;
    send_frame(12'h095);
    checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL single_press_valid: got %b want 1", evt_valid); end
    checks++; if ({evt_release, evt_addr, evt_cmd} !== {1'b0, 5'h01, 7'h15}) begin
      failures++; $display("FAIL single_press_fields: got rel=%b addr=%h cmd=%h want rel=0 addr=01 cmd=15", evt_release, evt_addr, evt_cmd); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL single_key_held: got %b want 1", key_held); end
    evt_ready = 1'b1;
    repeat (99) @(negedge clk);
    checks++; if ({evt_valid, key_held} !== 2'b01) begin
      failures++; $display("FAIL single_before_release: got valid=%b held=%b want valid=0 held=1", evt_valid, key_held); end
    @(negedge clk);
    checks++; if ({evt_valid, evt_release, evt_addr, evt_cmd} !== {1'b1, 1'b1, 5'h01, 7'h15}) begin
      failures++; $display("FAIL single_release: got v=%b rel=%b addr=%h cmd=%h want v=1 rel=1 addr=01 cmd=15", evt_valid, evt_release, evt_addr, evt_cmd); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL single_key_released: got %b want 0", key_held); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    int presses = 0, rels = 0, reps = 0, rel_at = -1;
    evt_ready = 1'b1;
    ir_data   = 12'h095;
    for (int c = 0; c < 400; c++) begin
      if (evt_valid) begin
        if (evt_release) begin rels++; rel_at = c; end
        else if (rep_bit) reps++;
        else presses++;
      end
      ir_data_rdy = (c % 60 == 0) && (c < 300);
      @(negedge clk);
    end
    ir_data_rdy = 1'b0;
    checks++; if (presses != 1) begin failures++; $display("FAIL hold_presses: got %0d want 1", presses); end
    checks++; if (rels != 1) begin failures++; $display("FAIL hold_releases: got %0d want 1", rels); end
    checks++; if (rel_at != 341) begin failures++; $display("FAIL hold_release_cycle: got %0d want 341", rel_at); end
    checks++; if (reps != EXP_REPEATS) begin failures++; $display("FAIL hold_repeats: got %0d want %0d", reps, EXP_REPEATS); end
  endtask

  task automatic test_code_change();
    logic [7:0] ev_code [8];
    int         ev_at [8];
    int         n = 0, drops = 0;
    for (int i = 0; i < 8; i++) begin ev_code[i] = 8'h00; ev_at[i] = -1; end
    evt_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (evt_valid && n < 8) begin ev_code[n] = {evt_release, evt_cmd}; ev_at[n] = c; n++; end
      if (c >= 1 && c <= 130 && !key_held) drops++;
      ir_data     = (c < 30) ? 12'h090 : 12'h091;
      ir_data_rdy = (c == 0) || (c == 30);
      @(negedge clk);
    end
    ir_data_rdy = 1'b0;
    checks++; if (n != 3) begin failures++; $display("FAIL change_event_count: got %0d want 3", n); end
    checks++; if (ev_code[0] !== 8'h10) begin failures++; $display("FAIL change_first_press: got %h want 10", ev_code[0]); end
    checks++; if (ev_code[1] !== 8'h11) begin failures++; $display("FAIL change_second_press: got %h want 11", ev_code[1]); end
    checks++; if (ev_code[2] !== 8'h91) begin failures++; $display("FAIL change_release: got %h want 91", ev_code[2]); end
    checks++; if (ev_at[2] != 131) begin failures++; $display("FAIL change_release_cycle: got %0d want 131", ev_at[2]); end
    checks++; if (drops != 0) begin failures++; $display("FAIL change_key_held_gap: got %0d low cycles want 0", drops); end
  endtask

  task automatic test_addr_filter();
    f_ready = 1'b0;
    f_data  = 12'h115;
    f_rdy   = 1'b1;
    @(negedge clk);
    f_rdy = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({f_valid, f_key_held} !== 2'b00) begin
      failures++; $display("FAIL filter_reject: got valid=%b held=%b want 00", f_valid, f_key_held); end
    f_data = 12'h095;
    f_rdy  = 1'b1;
    @(negedge clk);
    f_rdy = 1'b0;
    checks++; if ({f_valid, f_release, f_addr, f_cmd, f_key_held} !== {1'b1, 1'b0, 5'h01, 7'h15, 1'b1}) begin
      failures++; $display("FAIL filter_accept: got v=%b rel=%b addr=%h cmd=%h held=%b want 1 0 01 15 1", f_valid, f_release, f_addr, f_cmd, f_key_held); end
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send_frame(12'h0A0 + 12'(k % 2));
      repeat (4) @(negedge clk);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    checks++; if ({key_held, held_cmd} !== {1'b1, 7'h21}) begin
      failures++; $display("FAIL bp_held: got held=%b cmd=%h want 1 21", key_held, held_cmd); end
    repeat (5) begin
      if ({evt_valid, evt_release, evt_cmd} !== {1'b1, 1'b0, 7'h20}) unstable++;
      @(negedge clk);
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL bp_head_stable: got %0d unstable cycles want 0", unstable); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({evt_valid, evt_release, evt_cmd} !== {1'b1, 1'b0, 7'h20 + 7'(i % 2)}) begin
        failures++; $display("FAIL bp_pop%0d: got v=%b rel=%b cmd=%h want v=1 rel=0 cmd=%h", i, evt_valid, evt_release, evt_cmd, 7'h20 + 7'(i % 2)); end
      @(negedge clk);
    end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b want 0", evt_valid); end
    repeat (120) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    int seen = 0;
    evt_ready = 1'b0;
    send_frame(12'h0B0);
    repeat (2) @(negedge clk);
    send_frame(12'h0B1);
    repeat (2) @(negedge clk);
    checks++; if ({evt_valid, key_held} !== 2'b11) begin
      failures++; $display("FAIL midrst_setup: got valid=%b held=%b want 11", evt_valid, key_held); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({evt_valid, key_held, overflow} !== 3'b000) begin
      failures++; $display("FAIL midrst_cleared: got valid=%b held=%b ovf=%b want 000", evt_valid, key_held, overflow); end
    evt_ready = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (evt_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_release: got %0d event cycles want 0", seen); end
  endtask

  task automatic test_random();
    ev_t         head;
    logic [11:0] code;
    rst_n = 1'b0; ir_data_rdy = 1'b0; evt_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    code = 12'h095;
    for (int c = 0; c < 4000; c++) begin
      head = (m_n != 0) ? m_list[0] : '0;
      checks++; if (evt_valid !== (m_n != 0)) begin
        failures++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, evt_valid, (m_n != 0)); end
      checks++; if ({evt_release, rep_bit, evt_addr, evt_cmd} !== head) begin
        failures++; $display("FAIL rnd_head c=%0d: got %h want %h", c, {evt_release, rep_bit, evt_addr, evt_cmd}, head); end
      checks++; if (key_held !== m_held) begin
        failures++; $display("FAIL rnd_key_held c=%0d: got %b want %b", c, key_held, m_held); end
      if (m_held) begin
        checks++; if (held_cmd !== m_hcmd) begin
          failures++; $display("FAIL rnd_held_cmd c=%0d: got %h want %h", c, held_cmd, m_hcmd); end
      end
      checks++; if (overflow !== m_ovf) begin
        failures++; $display("FAIL rnd_overflow c=%0d: got %b want %b", c, overflow, m_ovf); end
      if (ir_data_rdy) begin
        ir_data_rdy = ($urandom_range(0, 1) == 1);
      end else if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 9) < 4)
          code = {5'(1 + $urandom_range(0, 1)), 7'(7'h15 + $urandom_range(0, 1))};
        ir_data     = code;
        ir_data_rdy = 1'b1;
      end
      evt_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    ir_data_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_code_change();
    test_addr_filter();
    test_backpressure();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ir_key_event_decoder.md
Name: ir_key_event_decoder

Overview:
- Sits directly downstream of the SIRC-style 12-bit IR frame receiver and consumes its data/data_rdy outputs.
- Splits each frame into command and address fields, applies an address filter and tracks key-hold state across the remote's repeated frames.
- Emits press and release events through a FWFT event FIFO with a valid/ready handshake, for the UI/control logic.

Parameters:
- RELEASE_TIMEOUT, 3000000, clock cycles with no matching frame before a held key counts as released (60 ms at 50 MHz); must be >= 2.
- ADDR_MASK, 5'h00, address bits compared against ADDR_MATCH; 0 accepts all addresses.
- ADDR_MATCH, 5'h01, required address value on the masked bits.
- FIFO_DEPTH, 4, event FIFO depth; power of two, >= 2.

Ports:
- clk  input  1  system clock; also the receiver clock.
- rst_n  input  1  synchronous active-low reset.
- ir_data  input  12  receiver data; [6:0] is the command, [11:7] is the address (LSB-first frame order).
- ir_data_rdy  input  1  receiver data_rdy (level; stays high until the next bit starts).
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts the head event.
- evt_release  output  1  head event type: 1 = release, 0 = press.
- evt_cmd  output  7  head event command.
- evt_addr  output  5  head event address.
- key_held  output  1  a key is currently considered held.
- held_cmd  output  7  command of the held key; valid while key_held = 1.
- overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset:
  - Clock and reset: single clk domain; rst_n is synchronous and active-low.
  - On rst_n = 0 at a clock edge: FSM goes to IDLE; timer, FIFO pointers, count, edge register, overflow, key_held and held_cmd/held_addr all clear to 0.
  - evt_valid = 0 after reset. evt_release, evt_cmd and evt_addr read 0 while the FIFO is empty after reset.
  - Reset mid-hold discards the hold and all queued events; no release event is emitted.
- Frame detection:
  - A registered copy of ir_data_rdy (reset 0) feeds the edge detector.
  - Detection cycle T is a cycle with ir_data_rdy = 1 and the registered copy = 0.
  - The frame is accepted iff (ir_data[11:7] & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK). Rejected frames have no effect, including no timer restart.
  - A level held high across many cycles yields exactly one detection.
- FSM, IDLE:
  - On an accepted frame: push a press event {0, addr, cmd}, latch held_cmd/held_addr, clear the timer, go to HELD.
- FSM, HELD:
  - Timer increments every cycle, saturating at RELEASE_TIMEOUT.
  - Accepted frame with the same cmd and addr: timer clears to 0, no event (repeat frame).
  - Accepted frame with a different cmd or addr: push a press for the new code, latch it, clear the timer, stay in HELD. No release is emitted for the old code.
  - Timer == RELEASE_TIMEOUT-1 with no accepted frame this cycle: push release {1, held_addr, held_cmd}, go to IDLE.
  - Accepted frame and timeout in the same cycle: the frame wins and no release is emitted.
- key_held is 1 exactly when the FSM is in HELD, and is registered.
- Latency: a pushed event is visible at the FIFO head (evt_valid = 1) in cycle T+1 if the FIFO was empty.
- FIFO:
  - First-word-fall-through; the head fields are stable while evt_valid = 1 and evt_ready = 0.
  - Pop when evt_valid and evt_ready are both 1.
  - Push when full without a pop in the same cycle: event dropped, overflow set to 1 (sticky until reset). FSM state still updates.
  - Push and pop in the same cycle when full: both happen, no drop.
  - Push and pop in the same cycle when empty: the pushed event appears next cycle; no bypass.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Timer width is clog2(RELEASE_TIMEOUT+1); it never wraps.

Optional Feature:
- Macro: IR_KEY_REPEAT_EN.
- Defined:
  - Adds output evt_repeat (1 bit, head field, reset 0).
  - Each same-code repeat frame in HELD pushes an event {press, cmd, addr} with evt_repeat = 1.
  - Press and release events carry evt_repeat = 0.
  - FIFO entry width grows by 1.
- Undefined: no evt_repeat port; repeat frames only restart the timer.

Test Plan:
- Setup for all cases: RELEASE_TIMEOUT = 100, ADDR_MASK = 0, FIFO_DEPTH = 4.
- Single frame: ir_data = 12'h095 with a 1-cycle ir_data_rdy rise.
  - Required: evt_valid in T+1 with cmd = 7'h15, addr = 5'h01, release = 0; key_held = 1.
  - Required: release event with the same fields exactly 100 cycles after T, then key_held = 0.
- Hold: the same frame repeated every 60 cycles, 5 times.
  - Required: exactly one press, then one release 100 cycles after the last frame.
  - Required with IR_KEY_REPEAT_EN: 4 additional events with evt_repeat = 1.
- Code change: frame cmd 7'h10, then cmd 7'h11 30 cycles later.
  - Required: two press events (7'h10, 7'h11); key_held stays 1; one release for 7'h11 only.
- Address filter: ADDR_MASK = 5'h1F, ADDR_MATCH = 5'h01; frame with addr 5'h02.
  - Required: no event, key_held = 0. A frame with addr 5'h01 produces a press.
- Backpressure and overflow: evt_ready = 0, 6 alternating-code frames.
  - Required: 4 events queued, overflow = 1.
  - Then evt_ready = 1: the 4 events pop in order with stable fields.
- Reset mid-hold: rst_n = 0 for one cycle while in HELD with 2 queued events.
  - Required: next cycle evt_valid = 0, key_held = 0, overflow = 0, and no release emitted afterwards.
